// File: rtl/codec_pkg.sv
// codec_pkg: shared constants for the I2S codec interface.
// Holds the sample width, frame counter width, counter bit positions of the
// generated codec clocks, SCLK phase strobes and the active bit-slot window.
package codec_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 10;

  // Counter bits that directly drive the codec clocks (clk/4, clk/16, clk/1024)
  localparam int MCLK_BIT  = 1;
  localparam int SCLK_BIT  = 3;
  localparam int LRCLK_BIT = 9;

  // Low counter nibble on the cycle before SCLK rises / falls
  localparam logic [3:0] RISE_PH = 4'h7;
  localparam logic [3:0] FALL_PH = 4'hF;

  // I2S data occupies slots 1..16 of each half-frame (one-slot delay after LRCLK)
  localparam logic [4:0] FIRST_BIT = 5'd1;
  localparam logic [4:0] LAST_BIT  = 5'd16;

endpackage

// File: rtl/codec_clk_gen.sv
// codec_clk_gen: free-running frame counter, codec clocks and codec reset.
// Ports: clk/rst in; mclk/sclk/lrclk clocks, rise/fall strobes (cycle before
// SCLK edge), slot (bit slot within half-frame), rstn (codec reset, active-low).
module codec_clk_gen
  import codec_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic       mclk,
  output logic       sclk,
  output logic       lrclk,
  output logic       rise,
  output logic       fall,
  output logic [4:0] slot,
  output logic       rstn
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      rstn <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      // Release the codec on the first wrap so it always sees a full frame low
      if (cnt == '1) rstn <= 1'b1;
    end
  end

  // Clocks come straight from register bits, so they cannot glitch
  assign mclk  = cnt[MCLK_BIT];
  assign sclk  = cnt[SCLK_BIT];
  assign lrclk = cnt[LRCLK_BIT];
  assign rise  = (cnt[SCLK_BIT:0] == RISE_PH);
  assign fall  = (cnt[SCLK_BIT:0] == FALL_PH);
  assign slot  = cnt[LRCLK_BIT-1:SCLK_BIT+1];

endmodule

// File: rtl/codec_intf.sv
// codec_intf: I2S master between the audio codec and the equalizer core.
// Ports: clk/rst; lft_out/rht_out from core, SDout from codec ADC; lft_in/rht_in
// and one-cycle valid to core; MCLK/SCLK/LRCLK/SDin/RSTn to codec.
module codec_intf #(
  parameter int DATA_W = codec_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] lft_out,
  input  logic [DATA_W-1:0] rht_out,
  input  logic              SDout,
  output logic [DATA_W-1:0] lft_in,
  output logic [DATA_W-1:0] rht_in,
  output logic              valid,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              SDin,
  output logic              RSTn
);

  import codec_pkg::FIRST_BIT;
  import codec_pkg::LAST_BIT;

  logic       rise;
  logic       fall;
  logic [4:0] slot;

  codec_clk_gen u_clk_gen (
    .clk   (clk),
    .rst   (rst),
    .mclk  (MCLK),
    .sclk  (SCLK),
    .lrclk (LRCLK),
    .rise  (rise),
    .fall  (fall),
    .slot  (slot),
    .rstn  (RSTn)
  );

  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] lft_hold;
  logic              pair_done;
  logic [DATA_W-1:0] tx_lft;
  logic [DATA_W-1:0] tx_rht;
  logic [DATA_W-1:0] tx_word;
  logic [DATA_W-1:0] tx_sh;
  logic              rx_bit;

  assign rx_next = {rx_sh[DATA_W-2:0], SDout};
  // Capture only while the codec is out of reset, so the first frame seen is whole
  assign rx_bit  = RSTn && rise && (slot >= FIRST_BIT) && (slot <= LAST_BIT);
  assign tx_word = LRCLK ? tx_rht : tx_lft;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sh     <= '0;
      lft_hold  <= '0;
      pair_done <= 1'b0;
      lft_in    <= '0;
      rht_in    <= '0;
      valid     <= 1'b0;
      tx_lft    <= '0;
      tx_rht    <= '0;
      tx_sh     <= '0;
      SDin      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      pair_done <= 1'b0;

      // RX: shift MSB first; the last slot of each half closes a word
      if (rx_bit) begin
        rx_sh <= rx_next;
        if (slot == LAST_BIT) begin
          if (!LRCLK) lft_hold  <= rx_next;
          else        pair_done <= 1'b1;
        end
      end

      // Right word is complete in rx_sh one cycle after its last bit
      if (pair_done) begin
        lft_in <= lft_hold;
        rht_in <= rx_sh;
        valid  <= 1'b1;
      end

      // Core result for this pair goes out in the next frame
      if (valid) begin
        tx_lft <= lft_out;
        tx_rht <= rht_out;
      end

      // TX: change SDin just before SCLK falls so it is stable at every rise
      if (fall) begin
        if (slot == '0) begin
          SDin  <= tx_word[DATA_W-1];
          tx_sh <= tx_word << 1;
        end else if (slot < LAST_BIT) begin
          SDin  <= tx_sh[DATA_W-1];
          tx_sh <= tx_sh << 1;
        end else if (slot == LAST_BIT) begin
          SDin  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_codec_intf.sv
// tb_codec_intf: randomized bench for codec_intf with a frame-level I2S codec/core model.
// Ports: none (drives clk/rst, codec SDout, core lft_out/rht_out).
// Model: per-frame word tables indexed by frame number since reset release.
module tb_codec_intf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] lft_out = '0;
  logic [15:0] rht_out = '0;
  logic        SDout = 1'b0;
  logic [15:0] lft_in;
  logic [15:0] rht_in;
  logic        valid;
  logic        MCLK;
  logic        SCLK;
  logic        LRCLK;
  logic        SDin;
  logic        RSTn;

  codec_intf #(.DATA_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .lft_out (lft_out),
    .rht_out (rht_out),
    .SDout   (SDout),
    .lft_in  (lft_in),
    .rht_in  (rht_in),
    .valid   (valid),
    .MCLK    (MCLK),
    .SCLK    (SCLK),
    .LRCLK   (LRCLK),
    .SDin    (SDin),
    .RSTn    (RSTn)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model state: cycles since reset release, words the codec sends in each
  // frame, and words the core hands over (to be transmitted in frame k).
  int          tc;
  int          epoch;
  logic [15:0] ml [0:31];
  logic [15:0] mr [0:31];
  logic [15:0] tl [0:31];
  logic [15:0] tr [0:31];

  task automatic model_reset();
    tc = 0;
    for (int i = 0; i < 32; i++) begin
      ml[i] = '0; mr[i] = '0; tl[i] = '0; tr[i] = '0;
    end
  endtask

  task automatic check_in_reset();
    check("rst_lft_in", lft_in, 0);
    check("rst_rht_in", rht_in, 0);
    check("rst_valid",  valid,  0);
    check("rst_sdin",   SDin,   0);
    check("rst_rstn",   RSTn,   0);
    check("rst_mclk",   MCLK,   0);
    check("rst_sclk",   SCLK,   0);
    check("rst_lrclk",  LRCLK,  0);
  endtask

  // One cycle of model, evaluated at the falling edge
  task automatic step();
    logic [9:0]  p;
    logic [4:0]  s;
    int          k;
    logic [15:0] w;
    logic        e;
    p = 10'(tc % 1024);
    k = tc / 1024;
    s = p[8:4];

    check("mclk",  MCLK,  32'(p[1]));
    check("sclk",  SCLK,  32'(p[3]));
    check("lrclk", LRCLK, 32'(p[9]));
    check("rstn",  RSTn,  32'(k >= 1));
    check("valid", valid, 32'(k >= 1 && p == 10'd777));

    if (p == 10'd0) begin
      if (epoch == 0 && k == 1) begin
        ml[k] = 16'hA5C3; mr[k] = 16'h1234;
      end else if (epoch == 0 && k >= 2 && k <= 9) begin
        ml[k] = (k % 2 == 0) ? 16'hFFFF : 16'h0000;
        mr[k] = ~ml[k];
      end else begin
        ml[k] = 16'($urandom); mr[k] = 16'($urandom);
      end
    end

    if (k >= 1 && p == 10'd777) begin
      check("lft_in", lft_in, 32'(ml[k]));
      check("rht_in", rht_in, 32'(mr[k]));
    end
    if (k == 0 && p == 10'd900) begin
      check("pre_lft_in", lft_in, 0);
      check("pre_rht_in", rht_in, 0);
    end

    if (p[3:0] == 4'h7) begin
      w = p[9] ? tr[k] : tl[k];
      e = (s >= 5'd1 && s <= 5'd16) ? w[16 - s] : 1'b0;
      check("sdin", SDin, 32'(e));
    end

    // Codec ADC: word bits in slots 1..16, noise elsewhere
    if (k >= 1 && s >= 5'd1 && s <= 5'd16) begin
      w = p[9] ? mr[k] : ml[k];
      SDout = w[16 - s];
    end else begin
      SDout = 1'($urandom_range(0, 1));
    end

    // Core outputs: fixed for the loopback frame, otherwise changing every slot
    if (epoch == 0 && k <= 1 && p <= 10'd777) begin
      lft_out = 16'h8001; rht_out = 16'h7FFE;
    end else if (p[3:0] == 4'h3) begin
      lft_out = 16'($urandom); rht_out = 16'($urandom);
    end

    if (k >= 1 && p == 10'd777) begin
      tl[k+1] = lft_out;
      tr[k+1] = rht_out;
    end
  endtask

  task automatic run(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      step();
      @(negedge clk);
      tc++;
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_in_reset();
    rst = 1'b0;
    model_reset();
    epoch = 0;
    // Ten frames, stopping in the right half of frame 10 (cnt = 600)
    run(10 * 1024 + 600);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_in_reset();
    rst = 1'b0;
    model_reset();
    epoch = 1;
    run(4 * 1024 + 900);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
